// File: rtl/adc7478_pkg.sv
// Shared types and frame geometry for the AD7478 serial ADC controller.
package adc7478_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, QUIET} state_t;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int DATA_BITS  = 8;
  localparam int DATA_LSB   = 4;

endpackage

// File: rtl/adc7478_ctrl.sv
// AD7478 frame master: one 16-SCLK frame per accepted start, result strobed with eoc.
// state | meaning
// IDLE  | CS_n high, waiting for start
// SHIFT | CS_n low, 32 SCLK toggles, sample on each rise
// DONE  | last half-period after 16th rise, then eoc
// QUIET | CS_n high for QUIET_CYC cycles before IDLE
module adc7478_ctrl #(
  parameter int HALF_DIV  = 1,
  parameter int QUIET_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       adc_sdata,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       busy,
  output logic       eoc,
  output logic [7:0] data,
  output logic       frame_err
);
  import adc7478_pkg::*;

  localparam int HW = $clog2(HALF_DIV + 1);
  localparam int QW = $clog2(QUIET_CYC + 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_DIV - 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYC - 1);

  state_t                state;
  logic [HW-1:0]         half_cnt;
  logic [5:0]            edge_cnt;
  logic [QW-1:0]         quiet_cnt;
  logic [FRAME_BITS-1:0] shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b1;
      busy      <= 1'b0;
      eoc       <= 1'b0;
      data      <= '0;
      frame_err <= 1'b0;
      shift     <= '0;
      half_cnt  <= '0;
      edge_cnt  <= '0;
      quiet_cnt <= '0;
    end else begin
      eoc <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= SHIFT;
            adc_cs_n <= 1'b0;
            busy     <= 1'b1;
            half_cnt <= '0;
            edge_cnt <= '0;
          end
        end
        SHIFT: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            adc_sclk <= ~adc_sclk;
            edge_cnt <= edge_cnt + 6'd1;
            // sclk currently low means this edge is a rise: capture the bit
            if (!adc_sclk)
              shift <= {shift[FRAME_BITS-2:0], adc_sdata};
            if (edge_cnt == 6'd31)
              state <= DONE;
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        DONE: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt  <= '0;
            adc_cs_n  <= 1'b1;
            eoc       <= 1'b1;
            data      <= shift[DATA_LSB +: DATA_BITS];
            frame_err <= |shift[FRAME_BITS-1 -: LEAD_ZEROS];
            quiet_cnt <= '0;
            state     <= QUIET;
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        QUIET: begin
          if (quiet_cnt == QUIET_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            quiet_cnt <= quiet_cnt + QW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc7478_ctrl.sv
// Directed bench for adc7478_ctrl: instance A at HALF_DIV=1, instance B at HALF_DIV=2.
module tb_adc7478_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, sdata_a = 1'b0;
  logic       cs_a, sclk_a, busy_a, eoc_a, ferr_a;
  logic [7:0] data_a;
  logic       start_b = 1'b0, sdata_b = 1'b0;
  logic       cs_b, sclk_b, busy_b, eoc_b, ferr_b;
  logic [7:0] data_b;

  adc7478_ctrl #(.HALF_DIV(1), .QUIET_CYC(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .adc_sdata(sdata_a),
    .adc_cs_n(cs_a), .adc_sclk(sclk_a), .busy(busy_a), .eoc(eoc_a),
    .data(data_a), .frame_err(ferr_a));

  adc7478_ctrl #(.HALF_DIV(2), .QUIET_CYC(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .adc_sdata(sdata_b),
    .adc_cs_n(cs_b), .adc_sclk(sclk_b), .busy(busy_b), .eoc(eoc_b),
    .data(data_b), .frame_err(ferr_b));

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc++;

  // ADC model A: frame word latched at CS_n fall, one bit per SCLK fall, MSB first
  logic [15:0] next_a = '0, frame_a = '0;
  int idx_a = 0, rises_a = 0, eocs_a = 0, falls_a = 0, fall_t_a = 0, low_a = 0;
  always @(negedge cs_a) begin frame_a = next_a; idx_a = 15; falls_a++; fall_t_a = cyc; end
  always @(posedge cs_a) low_a = cyc - fall_t_a;
  always @(negedge sclk_a) if (cs_a === 1'b0 && idx_a >= 0) begin sdata_a = frame_a[idx_a]; idx_a--; end
  always @(posedge sclk_a) if (cs_a === 1'b0) rises_a++;
  always @(posedge clk) if (eoc_a === 1'b1) eocs_a++;

  // ADC model B: successive frames take successive samples
  logic [7:0]  seq_b [3] = '{8'h11, 8'h22, 8'h33};
  logic [15:0] frame_b = '0;
  int idx_b = 0, fi_b = 0, falls_b = 0;
  int fall_tb [4] = '{0, 0, 0, 0};
  always @(negedge cs_b) begin
    frame_b = {4'h0, (fi_b < 3) ? seq_b[fi_b] : 8'h00, 4'h0};
    fi_b++;
    idx_b = 15;
    if (falls_b < 4) fall_tb[falls_b] = cyc;
    falls_b++;
  end
  always @(negedge sclk_b) if (cs_b === 1'b0 && idx_b >= 0) begin sdata_b = frame_b[idx_b]; idx_b--; end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_eoc_a(input string tag);
    int n = 0;
    while (eoc_a !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk(tag, 32'(eoc_a === 1'b1), 32'd1);
  endtask

  task automatic pulse_a(input logic [15:0] fr);
    next_a = fr;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  logic [7:0] dseq [3];
  int got, n, e0, f0, bad;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cs", cs_a, 1);
    chk("rst_sclk", sclk_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_eoc", eoc_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_ferr", ferr_a, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: single frame, 0xA5
    rises_a = 0;
    pulse_a({4'h0, 8'hA5, 4'h0});
    chk("t1_cs_fall", cs_a, 0);
    chk("t1_busy", busy_a, 1);
    chk("t1_sclk_hold", sclk_a, 1);
    wait_eoc_a("t1_eoc");
    chk("t1_data", data_a, 8'hA5);
    chk("t1_ferr", ferr_a, 0);
    chk("t1_cs_rise", cs_a, 1);
    chk("t1_busy_eoc", busy_a, 1);
    @(negedge clk);
    chk("t1_eoc_1cyc", eoc_a, 0);
    repeat (3) @(negedge clk);
    chk("t1_busy_end", busy_a, 0);
    chk("t1_cs_low", low_a, 33);
    chk("t1_rises", rises_a, 16);
    chk("t1_eoc_cnt", eocs_a, 1);

    // 2: bad leading zeros, then a clean frame
    pulse_a({4'b0100, 8'h3C, 4'h0});
    wait_eoc_a("t2_eoc");
    chk("t2_data", data_a, 8'h3C);
    chk("t2_ferr", ferr_a, 1);
    repeat (3) @(negedge clk);
    pulse_a({4'h0, 8'hFF, 4'h0});
    chk("t2_data_held", data_a, 8'h3C);
    chk("t2_ferr_held", ferr_a, 1);
    wait_eoc_a("t2b_eoc");
    chk("t2b_data", data_a, 8'hFF);
    chk("t2b_ferr", ferr_a, 0);

    // 3: back-to-back on B
    repeat (3) @(negedge clk);
    start_b = 1'b1;
    got = 0; n = 0;
    while (got < 3 && n < 1000) begin
      @(negedge clk); n++;
      if (eoc_b === 1'b1) begin
        dseq[got] = data_b;
        got++;
        if (got == 3) start_b = 1'b0;
      end
    end
    start_b = 1'b0;
    repeat (150) @(negedge clk);
    chk("t3_eoc_cnt", got, 3);
    chk("t3_d0", dseq[0], 8'h11);
    chk("t3_d1", dseq[1], 8'h22);
    chk("t3_d2", dseq[2], 8'h33);
    chk("t3_falls", falls_b, 3);
    chk("t3_period1", fall_tb[1] - fall_tb[0], 69);
    chk("t3_period2", fall_tb[2] - fall_tb[1], 69);
    chk("t3_ferr", ferr_b, 0);

    // 4: reset at the 8th rise
    rises_a = 0;
    pulse_a({4'h0, 8'h96, 4'h0});
    n = 0;
    while (rises_a < 8 && n < 200) begin @(negedge clk); n++; end
    chk("t4_reach_rise8", rises_a, 8);
    e0 = eocs_a;
    reset = 1'b1;
    @(negedge clk);
    chk("t4_cs", cs_a, 1);
    chk("t4_sclk", sclk_a, 1);
    chk("t4_busy", busy_a, 0);
    chk("t4_data", data_a, 8'h00);
    chk("t4_eoc", eoc_a, 0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("t4_no_eoc", eocs_a - e0, 0);
    pulse_a({4'h0, 8'h5A, 4'h0});
    wait_eoc_a("t4b_eoc");
    chk("t4b_data", data_a, 8'h5A);
    chk("t4b_ferr", ferr_a, 0);

    // 5: start wiggled during SHIFT and QUIET
    repeat (3) @(negedge clk);
    e0 = eocs_a; f0 = falls_a;
    pulse_a({4'h0, 8'hC3, 4'h0});
    repeat (10) @(negedge clk);
    start_a = 1'b1;
    repeat (3) @(negedge clk);
    start_a = 1'b0;
    wait_eoc_a("t5_eoc");
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (80) @(negedge clk);
    chk("t5_one_eoc", eocs_a - e0, 1);
    chk("t5_one_frame", falls_a - f0, 1);
    chk("t5_data", data_a, 8'hC3);

    // 6: idle with start low
    e0 = eocs_a; bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (cs_a !== 1'b1 || sclk_a !== 1'b1 || eoc_a !== 1'b0) bad++;
    end
    chk("t6_idle_pins", bad, 0);
    chk("t6_no_eoc", eocs_a - e0, 0);
    chk("t6_data", data_a, 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
